// File: rtl/csr_apb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : csr_apb_regfile
// Description : APB slave register file in front of the ALU command/result
//               FIFOs. Holds an op/id control word plus NUM_OPERANDS operand
//               registers and launches them as one command over a
//               valid/ready handshake. Results are prefetched into a RESULT
//               register that is popped by a read. Adds sticky W1C error
//               flags and a registered interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_apb_regfile #(
  parameter int APB_BUS_SIZE   = 32,
  parameter int ADDR_W         = 8,
  parameter int NUM_OPERANDS   = 2,
  parameter int DATA_SIZE      = 16,
  parameter int OPERATION_BIT  = 1,
  parameter int OPERATION_SIZE = 2,
  parameter int ID_BIT         = 8,
  parameter int ID_SIZE        = 8,
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int CMD_W          = NUM_OPERANDS*DATA_SIZE + ID_SIZE + OPERATION_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_W-1:0]         paddr,
  input  logic [APB_BUS_SIZE-1:0]   pwdata,
  output logic [APB_BUS_SIZE-1:0]   prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [CMD_W-1:0]          cmd_data,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [FIFO_OUT_WIDTH-1:0] res_data,
  input  logic                      fifo_in_full,
  input  logic                      fifo_out_empty,
  output logic                      irq
);

  // Word indices of the register map (byte address >> 2).
  localparam int c_IDX_W         = ADDR_W - 2;
  localparam int c_IDX_CTRL      = 0;
  localparam int c_IDX_STATUS    = 1;
  localparam int c_IDX_ERR       = 2;
  localparam int c_IDX_RESULT    = 3;
  localparam int c_IDX_DATA_BASE = 4;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;

  logic [OPERATION_SIZE-1:0]    r_op;
  logic [ID_SIZE-1:0]           r_id;
  logic                         r_irq_en;
  logic [APB_BUS_SIZE-1:0]      r_data [NUM_OPERANDS];
  logic [3:0]                   r_err;
  logic [FIFO_OUT_WIDTH-1:0]    r_res;
  logic                         r_res_full;
  logic                         r_rd_snap;
  logic                         r_in_full_q;
  logic                         r_out_empty_q;
  logic [APB_BUS_SIZE-1:0]      r_prdata;
  logic                         r_irq;

  logic                         w_setup;
  logic                         w_access;
  logic                         w_wr;
  logic                         w_rd;
  logic [c_IDX_W-1:0]           w_idx;
  logic [31:0]                  w_idx32;
  logic                         w_is_ctrl;
  logic                         w_is_status;
  logic                         w_is_err;
  logic                         w_is_result;
  logic [NUM_OPERANDS-1:0]      w_data_hit;
  logic                         w_is_data;
  logic                         w_unmapped;
  logic                         w_busy;
  logic                         w_ctrl_wr;
  logic                         w_data_wr;
  logic                         w_blocked;
  logic                         w_pop;
  logic [3:0]                   w_err_set;
  logic [3:0]                   w_err_clr;
  logic [APB_BUS_SIZE-1:0]      w_rdata;
  logic                         w_unused;

  // --------------------------------------------------------------------------
  // Address decode and access qualification
  // --------------------------------------------------------------------------
  assign w_setup     = psel & ~penable;
  assign w_access    = psel & penable;
  assign w_wr        = w_access & pwrite;
  assign w_rd        = w_access & ~pwrite;
  assign w_idx       = paddr[ADDR_W-1:2];
  assign w_idx32     = 32'(w_idx);
  assign w_is_ctrl   = (w_idx32 == 32'(c_IDX_CTRL));
  assign w_is_status = (w_idx32 == 32'(c_IDX_STATUS));
  assign w_is_err    = (w_idx32 == 32'(c_IDX_ERR));
  assign w_is_result = (w_idx32 == 32'(c_IDX_RESULT));

  // One-hot hit on the implemented operand registers only.
  always_comb begin
    w_data_hit = '0;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      w_data_hit[k] = (w_idx32 == 32'(c_IDX_DATA_BASE + k));
    end
  end

  assign w_is_data  = |w_data_hit;
  assign w_unmapped = ~(w_is_ctrl | w_is_status | w_is_err | w_is_result | w_is_data);

  assign w_busy     = (r_state == ST_PENDING);
  assign w_ctrl_wr  = w_wr & w_is_ctrl;
  assign w_data_wr  = w_wr & w_is_data;
  assign w_blocked  = w_busy & (w_ctrl_wr | w_data_wr);

  // The pop only consumes a result that was actually returned at setup time,
  // so a capture landing between setup and access is never silently lost.
  assign w_pop      = w_rd & w_is_result & r_rd_snap;

  assign w_err_set[0] = w_ctrl_wr & w_busy & pwdata[0];
  assign w_err_set[1] = w_rd & w_is_result & ~r_rd_snap;
  assign w_err_set[2] = w_blocked;
  assign w_err_set[3] = w_access & w_unmapped;
  assign w_err_clr    = (w_wr & w_is_err) ? pwdata[3:0] : 4'b0000;

  assign pready  = 1'b1;
  assign pslverr = w_access & (w_unmapped | w_blocked);
  assign prdata  = r_prdata;
  assign irq     = r_irq;
  assign res_ready = ~r_res_full;

  // --------------------------------------------------------------------------
  // Command FSM
  // --------------------------------------------------------------------------
  // State register; reset drops any pending command without a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and cmd_valid decode.
  always_comb begin
    w_state_nxt = r_state;
    cmd_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ctrl_wr && pwdata[0]) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        cmd_valid = 1'b1;
        if (cmd_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control fields update on any CTRL write accepted while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_id     <= '0;
      r_irq_en <= 1'b0;
    end else if (w_ctrl_wr && !w_busy) begin
      r_op     <= pwdata[OPERATION_BIT +: OPERATION_SIZE];
      r_id     <= pwdata[ID_BIT +: ID_SIZE];
      r_irq_en <= pwdata[APB_BUS_SIZE-1];
    end
  end

  // Operand registers, frozen while a command is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OPERANDS; k++) r_data[k] <= '0;
    end else if (w_data_wr && !w_busy) begin
      for (int k = 0; k < NUM_OPERANDS; k++) begin
        if (w_data_hit[k]) r_data[k] <= pwdata;
      end
    end
  end

  // Command word packing: operands above id above op.
  assign cmd_data[OPERATION_SIZE-1:0]       = r_op;
  assign cmd_data[OPERATION_SIZE +: ID_SIZE] = r_id;
  generate
    for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_pack
      assign cmd_data[OPERATION_SIZE + ID_SIZE + g*DATA_SIZE +: DATA_SIZE] = r_data[g][DATA_SIZE-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Result prefetch, status, errors, interrupt
  // --------------------------------------------------------------------------
  // Capture a result whenever the holding register is empty; a read pops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res      <= '0;
      r_res_full <= 1'b0;
    end else if (!r_res_full && res_valid) begin
      r_res      <= res_data;
      r_res_full <= 1'b1;
    end else if (w_pop) begin
      r_res_full <= 1'b0;
    end
  end

  // Remember whether the RESULT value driven at setup was valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rd_snap <= 1'b0;
    else if (w_setup) r_rd_snap <= r_res_full;
  end

  // FIFO status flags are registered before being reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_full_q   <= 1'b0;
      r_out_empty_q <= 1'b0;
    end else begin
      r_in_full_q   <= fifo_in_full;
      r_out_empty_q <= fifo_out_empty;
    end
  end

  // Sticky error flags: write-1-to-clear, a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 4'b0000;
    else        r_err <= (r_err & ~w_err_clr) | w_err_set;
  end

  // Registered interrupt from pending result (if enabled) or any error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= (r_irq_en & r_res_full) | (|r_err);
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  // Read data mux; unmapped and empty RESULT read as zero.
  always_comb begin
    w_rdata = '0;
    if (w_is_ctrl) begin
      w_rdata[0]                                 = w_busy;
      w_rdata[OPERATION_BIT +: OPERATION_SIZE]   = r_op;
      w_rdata[ID_BIT +: ID_SIZE]                 = r_id;
      w_rdata[APB_BUS_SIZE-1]                    = r_irq_en;
    end else if (w_is_status) begin
      w_rdata[3:0] = {r_res_full, w_busy, r_out_empty_q, r_in_full_q};
    end else if (w_is_err) begin
      w_rdata[3:0] = r_err;
    end else if (w_is_result) begin
      if (r_res_full) w_rdata[FIFO_OUT_WIDTH-1:0] = r_res;
    end else begin
      for (int k = 0; k < NUM_OPERANDS; k++) begin
        if (w_data_hit[k]) w_rdata = r_data[k];
      end
    end
  end

  // prdata is loaded in setup, held through access, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_prdata <= '0;
    else if (w_setup)   r_prdata <= pwrite ? '0 : w_rdata;
    else if (!w_access) r_prdata <= '0;
  end

  assign w_unused = ^{1'b0, paddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_csr_apb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_apb_regfile
// Description : Directed self-checking bench for csr_apb_regfile with the
//               default parameter set (two operands, 42-bit command).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_apb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        cmd_valid, cmd_ready;
  logic [41:0] cmd_data;
  logic        res_valid, res_ready;
  logic [24:0] res_data;
  logic        fifo_in_full, fifo_out_empty;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  csr_apb_regfile dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .fifo_in_full   (fifo_in_full),
    .fifo_out_empty (fifo_out_empty),
    .irq            (irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1 e = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata; e = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; cmd_ready = 1'b0; res_valid = 1'b0;
    res_data = '0; fifo_in_full = 1'b0; fifo_out_empty = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_prdata",    64'(prdata),    64'h0);
    check("rst_pslverr",   64'(pslverr),   64'h0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'h0);
    check("rst_res_ready", 64'(res_ready), 64'h1);
    check("rst_irq",       64'(irq),       64'h0);
    check("rst_cmd_data",  64'(cmd_data),  64'h0);
    check("pready",        64'(pready),    64'h1);
    rst_n = 1'b1;

    apb_read(8'h04, rd, er);
    check("status_after_reset", 64'(rd), 64'h2);

    // Load operands and launch with cmd_ready held low
    apb_write(8'h10, 32'h0000_1234, er);
    check("wr_data0_err", 64'(er), 64'h0);
    apb_write(8'h14, 32'h0000_ABCD, er);
    apb_write(8'h00, 32'h0000_5A05, er);
    check("start_err", 64'(er), 64'h0);
    check("cmd_valid_after_start", 64'(cmd_valid), 64'h1);
    check("cmd_data_packed", 64'(cmd_data), 64'h2AF3_448D_16A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cmd_valid_held", 64'(cmd_valid), 64'h1);
    end

    // Writes while pending are rejected and flagged
    apb_write(8'h10, 32'h0000_9999, er);
    check("busy_data_wr_slverr", 64'(er), 64'h1);
    apb_write(8'h00, 32'h0000_0001, er);
    check("busy_ctrl_wr_slverr", 64'(er), 64'h1);
    check("cmd_data_stable", 64'(cmd_data), 64'h2AF3_448D_16A);
    apb_read(8'h00, rd, er);
    check("ctrl_read_pending", 64'(rd), 64'h5A05);
    apb_read(8'h08, rd, er);
    check("err_busy_overflow", 64'(rd), 64'h5);
    check("irq_on_err", 64'(irq), 64'h1);
    apb_write(8'h08, 32'h0000_0005, er);
    apb_read(8'h08, rd, er);
    check("err_cleared", 64'(rd), 64'h0);
    check("irq_after_clear", 64'(irq), 64'h0);

    // Handshake
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("cmd_valid_after_hs", 64'(cmd_valid), 64'h0);
    cmd_ready = 1'b0;
    apb_read(8'h10, rd, er);
    check("data0_unchanged", 64'(rd), 64'h1234);

    // Result capture and read-to-pop
    @(negedge clk);
    res_valid = 1'b1; res_data = 25'h1AB_CDEF; fifo_out_empty = 1'b0;
    #1 check("res_ready_before_capture", 64'(res_ready), 64'h1);
    @(negedge clk);
    check("res_ready_after_capture", 64'(res_ready), 64'h0);
    res_data = 25'h000_0055;
    @(negedge clk);
    res_valid = 1'b0;
    apb_read(8'h04, rd, er);
    check("status_res_full", 64'(rd), 64'h8);
    apb_read(8'h0C, rd, er);
    check("result_value", 64'(rd), 64'h01AB_CDEF);
    check("result_slverr", 64'(er), 64'h0);
    check("res_ready_after_pop", 64'(res_ready), 64'h1);
    apb_read(8'h0C, rd, er);
    check("result_empty_value", 64'(rd), 64'h0);
    check("result_empty_slverr", 64'(er), 64'h0);
    apb_read(8'h08, rd, er);
    check("err_underflow", 64'(rd), 64'h2);
    apb_write(8'h08, 32'h0000_0002, er);

    // Interrupt on pending result when enabled
    apb_write(8'h00, 32'h8000_0000, er);
    apb_read(8'h00, rd, er);
    check("ctrl_irq_en", 64'(rd), 64'h8000_0000);
    check("irq_idle", 64'(irq), 64'h0);
    @(negedge clk);
    res_valid = 1'b1; res_data = 25'h000_0123;
    @(negedge clk);
    res_valid = 1'b0;
    check("irq_not_yet", 64'(irq), 64'h0);
    @(negedge clk);
    check("irq_rise", 64'(irq), 64'h1);
    apb_read(8'h0C, rd, er);
    check("result_second", 64'(rd), 64'h123);
    @(negedge clk);
    check("irq_fall", 64'(irq), 64'h0);

    // Decode errors and ignored writes
    apb_read(8'h40, rd, er);
    check("unmapped_rd_data", 64'(rd), 64'h0);
    check("unmapped_rd_slverr", 64'(er), 64'h1);
    apb_read(8'h08, rd, er);
    check("err_decode", 64'(rd), 64'h8);
    apb_write(8'h18, 32'h0000_FFFF, er);
    check("data2_wr_slverr", 64'(er), 64'h1);
    apb_write(8'h08, 32'h0000_0008, er);
    apb_write(8'h04, 32'h0000_000F, er);
    check("status_wr_slverr", 64'(er), 64'h0);
    apb_read(8'h08, rd, er);
    check("err_after_status_wr", 64'(rd), 64'h0);

    // Reset while pending drops the command
    apb_write(8'h00, 32'h0000_0003, er);
    check("cmd_valid_second", 64'(cmd_valid), 64'h1);
    check("cmd_data_second", 64'(cmd_data), 64'h2AF3_448D_001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("cmd_valid_async_rst", 64'(cmd_valid), 64'h0);
    check("cmd_data_async_rst",  64'(cmd_data),  64'h0);
    check("irq_async_rst",       64'(irq),       64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_apb_regfile.md
# csr_apb_regfile

Parametrised APB slave register file fronting the ALU command/result FIFOs; successor to the fixed CTRL/DATA0/DATA1/RESULT register set. Holds an operation/ID control word and NUM_OPERANDS operand registers, launches commands through a valid/ready handshake toward FIFO_IN, and prefetches results from FIFO_OUT into a read-to-pop RESULT register. It adds address decode, busy protection, sticky write-1-to-clear error flags and an interrupt output.

## Interface
- APB_BUS_SIZE, 32: APB data width.
- ADDR_W, 8: PADDR width (byte address, word aligned).
- NUM_OPERANDS, 2: operand registers DATA_0..DATA_{N-1}; 1..8.
- DATA_SIZE, 16: operand bits forwarded per DATA register (low bits).
- OPERATION_BIT, 1 / OPERATION_SIZE, 2: op field position and width in CTRL.
- ID_BIT, 8 / ID_SIZE, 8: id field position and width in CTRL.
- FIFO_OUT_WIDTH, 25: result width (≤ APB_BUS_SIZE).
- CMD_W, derived: NUM_OPERANDS*DATA_SIZE + ID_SIZE + OPERATION_SIZE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- psel, penable, pwrite  in  1  APB control.
- paddr  in  ADDR_W  byte address.
- pwdata  in  APB_BUS_SIZE  write data.
- prdata  out  APB_BUS_SIZE  read data.
- pready  out  1  tied 1 (no wait states).
- pslverr  out  1  error response, valid in access phase.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  FIFO_IN accepts.
- cmd_data  out  CMD_W  {DATA_{N-1}[DATA_SIZE-1:0],…,DATA_0[DATA_SIZE-1:0], id, op}.
- res_valid  in  1  FIFO_OUT has data.
- res_ready  out  1  = ~res_full.
- res_data  in  FIFO_OUT_WIDTH  result word.
- fifo_in_full, fifo_out_empty  in  1  FIFO status.
- irq  out  1  interrupt, registered.

## Operation
- Access = psel & penable; decode paddr[ADDR_W-1:2]. Map: 0x00 CTRL, 0x04 STATUS (RO), 0x08 ERR (W1C), 0x0C RESULT (RO, read pops), 0x10+4k DATA_k.
- CTRL: [0] START (write 1 launches; reads as cmd_pending), op and id fields, [31] IRQ_EN; other bits read 0.
- STATUS: [0] fifo_in_full, [1] fifo_out_empty (both registered one cycle), [2] cmd_pending, [3] res_full.
- ERR: [0] overflow (START while pending), [1] underflow (RESULT read while ~res_full), [2] busy_write (CTRL/DATA write while pending), [3] decode error.
- Command FSM IDLE/PENDING. IDLE: CTRL write with pwdata[0]=1 loads op/id/IRQ_EN → PENDING. CTRL write with START=0 only updates fields. PENDING: cmd_valid=1; cmd_valid&cmd_ready → IDLE.
- While PENDING, any CTRL/DATA write is discarded, sets ERR[2] (plus ERR[0] if START=1), pslverr=1; cmd_data stays stable.
- Result: res_full=0 & res_valid → capture res_data, res_full=1. RESULT read returns zero-extended value and clears res_full. Read while empty returns 0, sets ERR[1], pslverr=0.
- Unmapped address (incl. DATA_k, k≥NUM_OPERANDS): write ignored, read returns 0, pslverr=1, ERR[3] set. Writes to STATUS/RESULT: ignored, no error.
- ERR write: bits with pwdata=1 clear; a set event in the same cycle wins.
- irq next cycle = (IRQ_EN & res_full) | (|ERR).

## Timing
- Reset: all registers 0, FSM IDLE; prdata=0, pslverr=0, cmd_valid=0, res_ready=1, irq=0, cmd_data=0.
- prdata registered in setup phase (psel & ~penable), stable through access; 0 when not reading.
- pslverr combinational during access only.
- START write in access cycle T → cmd_valid=1 at T+1; earliest handshake T+1; cmd_valid=0 the cycle after handshake.
- Back-to-back: new START accepted on the first cycle after returning to IDLE.
- Result handshake at cycle T (res_ready=1 combinational) → res_full=1, STATUS[3]=1 at T+1; RESULT read in access cycle T2 → res_ready=1 at T2+1, next capture no earlier than T2+1.
- Reset mid-command drops the pending command without handshake.

## Test plan
- Reset: all outputs at reset values; STATUS reads 0x2 when fifo_out_empty=1.
- Write DATA_0=0x1234, DATA_1=0xABCD, CTRL=0x0000_5A05 (id 0x5A, op 2, START) with cmd_ready=0 for 3 cycles → cmd_valid high from T+1, cmd_data={0xABCD,0x1234,0x5A,2′b10}, clears one cycle after cmd_ready=1.
- During PENDING, write DATA_0 and CTRL START → pslverr=1, DATA_0 unchanged, ERR reads 0x5; write ERR=0x5 → ERR=0.
- res_valid with res_data=0x1ABCDEF → res_ready drops next cycle; RESULT read returns 0x01ABCDEF, res_full clears; second read returns 0 and sets ERR[1].
- IRQ_EN=1 and result captured → irq rises one cycle after res_full; pops → irq falls.
- Read 0x40 with NUM_OPERANDS=2 → prdata=0, pslverr=1, ERR[3]=1; assert rst_n low mid-PENDING → cmd_valid=0 immediately.
